// File: rtl/kvarb_pkg.sv
// Shared types and constants for the two-port key-value request arbiter.
// Statistics counters in kv_req_arbiter are built only when KVARB_STATS_EN is defined.
package kvarb_pkg;

  localparam logic [3:0] OP_SUSPECT      = 4'b0011;
  localparam logic [3:0] OP_ARREST       = 4'b0101;

  localparam logic [1:0] STATUS_SUSPECT  = 2'b01;
  localparam logic [1:0] STATUS_ARREST   = 2'b10;
  localparam logic [1:0] STATUS_FILTERED = 2'b11;

  localparam int PORT_ID_W = 1;
  localparam int NUM_PORTS = 2;

  typedef logic [PORT_ID_W-1:0] port_id_t;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOADED = 1'b1
  } out_state_e;

endpackage

// File: rtl/kvarb_tag_fifo.sv
// In-order FIFO of requesting port IDs for requests outstanding at the DB.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module kvarb_tag_fifo
  import kvarb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  port_id_t         push_data_i,
  input  logic             pop_i,
  output port_id_t         pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  port_id_t         mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kv_req_arbiter.sv
// Round-robin sharing of one KV DB lookup port between two parsers, with reply routing.
// Define KVARB_STATS_EN to build the drop and spurious-reply counters (tied to 0 otherwise).
module kv_req_arbiter
  import kvarb_pkg::*;
#(
  parameter int KEY_SIZE        = 96,
  parameter int FLAG_SIZE       = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   clk156,
  input  logic                   eth_rst_n,
  input  logic [1:0]             req_valid,
  input  logic [2*KEY_SIZE-1:0]  req_key,
  input  logic [2*FLAG_SIZE-1:0] req_flag,
  output logic [1:0]             rsp_valid,
  output logic [FLAG_SIZE-1:0]   rsp_flag,
  output logic                   db_in_valid,
  output logic [KEY_SIZE-1:0]    db_in_key,
  output logic [FLAG_SIZE-1:0]   db_in_flag,
  input  logic                   db_ready,
  input  logic                   db_out_valid,
  input  logic [FLAG_SIZE-1:0]   db_out_flag,
  output logic [31:0]            drop_cnt,
  output logic [15:0]            spurious_cnt
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  out_state_e            state_q, state_d;
  port_id_t              last_grant_q;
  port_id_t              out_port_q;
  logic [KEY_SIZE-1:0]   out_key_q;
  logic [FLAG_SIZE-1:0]  out_flag_q;
  logic [1:0]            rsp_valid_q;
  logic [FLAG_SIZE-1:0]  rsp_flag_q;

  logic [1:0]            cand_valid;
  logic [KEY_SIZE-1:0]   cand_key  [2];
  logic [FLAG_SIZE-1:0]  cand_flag [2];
  logic [1:0]            granted;
  logic                  grant;
  port_id_t              grant_port;
  logic                  accept;

  logic                  tag_push;
  logic                  tag_pop;
  logic                  tag_full;
  logic                  tag_empty;
  port_id_t              tag_head;
  logic [CNT_W-1:0]      tag_count;
  logic [CNT_W:0]        tag_count_after;
  logic                  room;

  assign accept   = (state_q == OUT_LOADED) && db_ready;
  assign tag_push = accept;
  assign tag_pop  = db_out_valid && !tag_empty;

  // A new grant must leave space in the tag FIFO for its own later push.
  assign tag_count_after = {1'b0, tag_count} + {{CNT_W{1'b0}}, tag_push}
                         - {{CNT_W{1'b0}}, tag_pop};
  assign room = (!tag_full || tag_pop) && (tag_count_after < (CNT_W+1)'(MAX_OUTSTANDING));

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic                 valid_q;
    logic [KEY_SIZE-1:0]  key_q;
    logic [FLAG_SIZE-1:0] flag_q;

    // An incoming pulse bypasses an empty holding register so it can be granted at once.
    assign cand_valid[gi] = valid_q | req_valid[gi];
    assign cand_key[gi]   = valid_q ? key_q  : req_key[gi*KEY_SIZE +: KEY_SIZE];
    assign cand_flag[gi]  = valid_q ? flag_q : req_flag[gi*FLAG_SIZE +: FLAG_SIZE];
    assign granted[gi]    = grant && (grant_port == port_id_t'(gi));

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
      if (!eth_rst_n) begin
        valid_q <= 1'b0;
        key_q   <= '0;
        flag_q  <= '0;
      end else if (req_valid[gi] && (valid_q ? granted[gi] : !granted[gi])) begin
        valid_q <= 1'b1;
        key_q   <= req_key[gi*KEY_SIZE +: KEY_SIZE];
        flag_q  <= req_flag[gi*FLAG_SIZE +: FLAG_SIZE];
      end else if (granted[gi]) begin
        valid_q <= 1'b0;
      end
    end

`ifdef KVARB_STATS_EN
    logic [15:0] drop_q;

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
      if (!eth_rst_n) begin
        drop_q <= '0;
      end else if (req_valid[gi] && valid_q && !granted[gi] && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end

    assign drop_cnt[gi*16 +: 16] = drop_q;
`endif
  end

  always_comb begin
    grant      = 1'b0;
    grant_port = '0;
    state_d    = state_q;
    if (((state_q == OUT_IDLE) || accept) && room) begin
      if (&cand_valid) begin
        grant      = 1'b1;
        grant_port = ~last_grant_q;
      end else if (cand_valid[0]) begin
        grant      = 1'b1;
        grant_port = port_id_t'(0);
      end else if (cand_valid[1]) begin
        grant      = 1'b1;
        grant_port = port_id_t'(1);
      end
    end
    case (state_q)
      OUT_IDLE:   if (grant) state_d = OUT_LOADED;
      OUT_LOADED: if (accept && !grant) state_d = OUT_IDLE;
      default:    state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q      <= OUT_IDLE;
      last_grant_q <= '0;
      out_port_q   <= '0;
      out_key_q    <= '0;
      out_flag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        out_key_q    <= cand_key[grant_port];
        out_flag_q   <= cand_flag[grant_port];
        out_port_q   <= grant_port;
        last_grant_q <= grant_port;
      end
    end
  end

  kvarb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk_i       (clk156),
    .rst_ni      (eth_rst_n),
    .push_i      (tag_push),
    .push_data_i (out_port_q),
    .pop_i       (db_out_valid),
    .pop_data_o  (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (tag_count)
  );

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      rsp_valid_q <= '0;
      rsp_flag_q  <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (tag_pop) begin
        rsp_valid_q <= (tag_head == port_id_t'(1)) ? 2'b10 : 2'b01;
        rsp_flag_q  <= db_out_flag;
      end
    end
  end

`ifdef KVARB_STATS_EN
  logic [15:0] spurious_q;

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      spurious_q <= '0;
    end else if (db_out_valid && tag_empty && (spurious_q != 16'hFFFF)) begin
      spurious_q <= spurious_q + 16'd1;
    end
  end

  assign spurious_cnt = spurious_q;
`else
  assign drop_cnt     = '0;
  assign spurious_cnt = '0;
`endif

  assign db_in_valid = (state_q == OUT_LOADED);
  assign db_in_key   = out_key_q;
  assign db_in_flag  = out_flag_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_flag    = rsp_flag_q;

endmodule

// File: tb/tb_kv_req_arbiter.sv
// Directed, table-driven bench for kv_req_arbiter plus hand-written multi-cycle sequences.
// Counter expectations follow KVARB_STATS_EN.
module tb_kv_req_arbiter;

  localparam int KS = 96;
  localparam int FS = 4;

`ifdef KVARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk156 = 1'b0;
  logic            eth_rst_n;
  logic [1:0]      req_valid;
  logic [2*KS-1:0] req_key;
  logic [2*FS-1:0] req_flag;
  logic [1:0]      rsp_valid;
  logic [FS-1:0]   rsp_flag;
  logic            db_in_valid;
  logic [KS-1:0]   db_in_key;
  logic [FS-1:0]   db_in_flag;
  logic            db_ready;
  logic            db_out_valid;
  logic [FS-1:0]   db_out_flag;
  logic [31:0]     drop_cnt;
  logic [15:0]     spurious_cnt;

  always #5 clk156 = ~clk156;

  kv_req_arbiter #(
    .KEY_SIZE        (KS),
    .FLAG_SIZE       (FS),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk156       (clk156),
    .eth_rst_n    (eth_rst_n),
    .req_valid    (req_valid),
    .req_key      (req_key),
    .req_flag     (req_flag),
    .rsp_valid    (rsp_valid),
    .rsp_flag     (rsp_flag),
    .db_in_valid  (db_in_valid),
    .db_in_key    (db_in_key),
    .db_in_flag   (db_in_flag),
    .db_ready     (db_ready),
    .db_out_valid (db_out_valid),
    .db_out_flag  (db_out_flag),
    .drop_cnt     (drop_cnt),
    .spurious_cnt (spurious_cnt)
  );

  typedef struct packed {
    logic [1:0]  rv;
    logic [95:0] k0;
    logic [95:0] k1;
    logic [3:0]  f0;
    logic [3:0]  f1;
    logic        rdy;
    logic        ov;
    logic [3:0]  of;
    logic        ev;
    logic [95:0] ek;
    logic [3:0]  ef;
    logic [1:0]  er;
    logic [3:0]  erf;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic [1:0] rv, input logic [95:0] k0, input logic [95:0] k1,
                              input logic [3:0] f0, input logic [3:0] f1, input logic rdy,
                              input logic ov, input logic [3:0] of, input logic ev,
                              input logic [95:0] ek, input logic [3:0] ef, input logic [1:0] er,
                              input logic [3:0] erf, input logic [31:0] ed);
    vec_t v;
    v.rv = rv; v.k0 = k0; v.k1 = k1; v.f0 = f0; v.f1 = f1; v.rdy = rdy; v.ov = ov; v.of = of;
    v.ev = ev; v.ek = ek; v.ef = ef; v.er = er; v.erf = erf; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk156);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " db_in_valid"}, 96'(db_in_valid), 96'h0);
    chk({tag, " db_in_key"}, db_in_key, 96'h0);
    chk({tag, " db_in_flag"}, 96'(db_in_flag), 96'h0);
    chk({tag, " rsp_valid"}, 96'(rsp_valid), 96'h0);
    chk({tag, " rsp_flag"}, 96'(rsp_flag), 96'h0);
    chk({tag, " drop_cnt"}, 96'(drop_cnt), 96'h0);
    chk({tag, " spurious_cnt"}, 96'(spurious_cnt), 96'h0);
  endtask

  initial begin
    logic [31:0] d1;
    logic [31:0] d2;
    logic [95:0] kb1;
    d1  = STATS ? 32'h0000_0001 : 32'h0;
    d2  = STATS ? 32'h0001_0001 : 32'h0;
    kb1 = 96'hFFEE_DDCC_BBAA_9988_7766_5544;

    //          rv     k0     k1     f0    f1    rdy   ov    of    ev    ek     ef    er     erf   ed
    // single request
    vecs.push_back(mk(2'b01, 96'h1, 96'h0, 4'h3, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 96'h1, 4'h3, 2'b00, 4'h0, 32'h0));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 96'h0, 4'h0, 2'b00, 4'h0, 32'h0));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h4, 1'b0, 96'h0, 4'h0, 2'b01, 4'h4, 32'h0));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 96'h0, 4'h0, 2'b00, 4'h0, 32'h0));
    // contention: port 1 first, then port 0
    vecs.push_back(mk(2'b11, 96'hA0, kb1,  4'h5, 4'h3, 1'b1, 1'b0, 4'h0, 1'b1, kb1,    4'h3, 2'b00, 4'h0, 32'h0));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 96'hA0, 4'h5, 2'b00, 4'h0, 32'h0));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h7, 1'b0, 96'h0,  4'h0, 2'b10, 4'h7, 32'h0));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h9, 1'b0, 96'h0,  4'h0, 2'b01, 4'h9, 32'h0));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 96'h0,  4'h0, 2'b00, 4'h0, 32'h0));
    // port 0 drop with DB stalled
    vecs.push_back(mk(2'b01, 96'hC, 96'h0, 4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 96'hC, 4'h1, 2'b00, 4'h0, 32'h0));
    vecs.push_back(mk(2'b01, 96'hD, 96'h0, 4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 96'hC, 4'h1, 2'b00, 4'h0, 32'h0));
    vecs.push_back(mk(2'b01, 96'hE, 96'h0, 4'h6, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 96'hC, 4'h1, 2'b00, 4'h0, d1));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 96'hD, 4'h2, 2'b00, 4'h0, d1));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 96'h0, 4'h0, 2'b00, 4'h0, d1));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0, 96'h0, 4'h0, 2'b01, 4'h2, d1));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h6, 1'b0, 96'h0, 4'h0, 2'b01, 4'h6, d1));
    vecs.push_back(mk(2'b00, 96'h0, 96'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 96'h0, 4'h0, 2'b00, 4'h0, d1));
    // port 1 drop, then round-robin between two held requests
    vecs.push_back(mk(2'b10, 96'h0,  96'hF,  4'h0, 4'h8, 1'b0, 1'b0, 4'h0, 1'b1, 96'hF,  4'h8, 2'b00, 4'h0, d1));
    vecs.push_back(mk(2'b10, 96'h0,  96'h16, 4'h0, 4'h9, 1'b0, 1'b0, 4'h0, 1'b1, 96'hF,  4'h8, 2'b00, 4'h0, d1));
    vecs.push_back(mk(2'b11, 96'h18, 96'h17, 4'hA, 4'hB, 1'b0, 1'b0, 4'h0, 1'b1, 96'hF,  4'h8, 2'b00, 4'h0, d2));
    vecs.push_back(mk(2'b00, 96'h0,  96'h0,  4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 96'h18, 4'hA, 2'b00, 4'h0, d2));
    vecs.push_back(mk(2'b00, 96'h0,  96'h0,  4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 96'h16, 4'h9, 2'b00, 4'h0, d2));
    vecs.push_back(mk(2'b00, 96'h0,  96'h0,  4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 96'h0,  4'h0, 2'b00, 4'h0, d2));
    vecs.push_back(mk(2'b00, 96'h0,  96'h0,  4'h0, 4'h0, 1'b1, 1'b1, 4'h1, 1'b0, 96'h0,  4'h0, 2'b10, 4'h1, d2));
    vecs.push_back(mk(2'b00, 96'h0,  96'h0,  4'h0, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0, 96'h0,  4'h0, 2'b01, 4'h2, d2));
    vecs.push_back(mk(2'b00, 96'h0,  96'h0,  4'h0, 4'h0, 1'b1, 1'b1, 4'h3, 1'b0, 96'h0,  4'h0, 2'b10, 4'h3, d2));
    vecs.push_back(mk(2'b00, 96'h0,  96'h0,  4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 96'h0,  4'h0, 2'b00, 4'h0, d2));

    // reset state
    eth_rst_n    = 1'b0;
    req_valid    = '0;
    req_key      = '0;
    req_flag     = '0;
    db_ready     = 1'b0;
    db_out_valid = 1'b0;
    db_out_flag  = '0;
    repeat (2) @(posedge clk156);
    #1;
    chk_all_zero("reset");
    eth_rst_n = 1'b1;
    step();
    chk("post-reset db_in_valid", 96'(db_in_valid), 96'h0);

    foreach (vecs[i]) begin
      req_valid    = vecs[i].rv;
      req_key      = {vecs[i].k1, vecs[i].k0};
      req_flag     = {vecs[i].f1, vecs[i].f0};
      db_ready     = vecs[i].rdy;
      db_out_valid = vecs[i].ov;
      db_out_flag  = vecs[i].of;
      step();
      $display("vec %0d: db_in_valid=%0b key=%0h rsp_valid=%b rsp_flag=%0h drop=%0h",
               i, db_in_valid, db_in_key, rsp_valid, rsp_flag, drop_cnt);
      chk($sformatf("v%0d db_in_valid", i), 96'(db_in_valid), 96'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d db_in_key", i), db_in_key, vecs[i].ek);
        chk($sformatf("v%0d db_in_flag", i), 96'(db_in_flag), 96'(vecs[i].ef));
      end
      chk($sformatf("v%0d rsp_valid", i), 96'(rsp_valid), 96'(vecs[i].er));
      if (vecs[i].er != 2'b00) begin
        chk($sformatf("v%0d rsp_flag", i), 96'(rsp_flag), 96'(vecs[i].erf));
      end
      chk($sformatf("v%0d drop_cnt", i), 96'(drop_cnt), 96'(vecs[i].ed));
      chk($sformatf("v%0d spurious_cnt", i), 96'(spurious_cnt), 96'h0);
    end
    req_valid    = '0;
    db_out_valid = 1'b0;
    db_ready     = 1'b1;

    // outstanding limit: 8 accepted, 9th waits for a reply
    for (int i = 0; i < 9; i++) begin
      req_valid = 2'b01;
      req_key   = {96'h0, 96'(100 + i)};
      req_flag  = 8'h0F;
      step();
      req_valid = '0;
      $display("limit req %0d: db_in_valid=%0b key=%0h", i, db_in_valid, db_in_key);
      if (i < 8) begin
        chk($sformatf("limit%0d issue", i), 96'(db_in_valid), 96'h1);
        chk($sformatf("limit%0d key", i), db_in_key, 96'(100 + i));
      end else begin
        chk("limit8 blocked", 96'(db_in_valid), 96'h0);
      end
      step();
      chk($sformatf("limit%0d accepted", i), 96'(db_in_valid), 96'h0);
      step();
    end
    step();
    chk("limit8 still blocked", 96'(db_in_valid), 96'h0);
    db_out_valid = 1'b1;
    db_out_flag  = 4'hA;
    step();
    db_out_valid = 1'b0;
    $display("limit reply: rsp_valid=%b db_in_valid=%0b key=%0h", rsp_valid, db_in_valid, db_in_key);
    chk("limit reply rsp_valid", 96'(rsp_valid), 96'h1);
    chk("limit reply rsp_flag", 96'(rsp_flag), 96'hA);
    chk("limit8 issue", 96'(db_in_valid), 96'h1);
    chk("limit8 key", db_in_key, 96'd108);
    step();
    chk("limit8 accepted", 96'(db_in_valid), 96'h0);
    chk("limit drop unchanged", 96'(drop_cnt), 96'(d2));

    // drain the 8 outstanding tags, then one spurious reply
    db_out_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      db_out_flag = 4'(i);
      step();
      $display("drain %0d: rsp_valid=%b rsp_flag=%0h", i, rsp_valid, rsp_flag);
      chk($sformatf("drain%0d rsp_valid", i), 96'(rsp_valid), 96'h1);
      chk($sformatf("drain%0d rsp_flag", i), 96'(rsp_flag), 96'(i));
    end
    db_out_flag = 4'hC;
    step();
    db_out_valid = 1'b0;
    $display("spurious: rsp_valid=%b spurious_cnt=%0d", rsp_valid, spurious_cnt);
    chk("spurious rsp_valid", 96'(rsp_valid), 96'h0);
    chk("spurious cnt", 96'(spurious_cnt), STATS ? 96'h1 : 96'h0);

    // async reset with 3 outstanding and one request presented
    for (int i = 0; i < 3; i++) begin
      req_valid = 2'b01;
      req_key   = {96'h0, 96'(200 + i)};
      step();
      req_valid = '0;
      step();
      step();
    end
    db_ready  = 1'b0;
    req_valid = 2'b10;
    req_key   = {96'h300, 96'h0};
    req_flag  = 8'h50;
    step();
    req_valid = '0;
    chk("pre-reset db_in_valid", 96'(db_in_valid), 96'h1);
    #2;
    eth_rst_n = 1'b0;
    #1;
    $display("async reset: db_in_valid=%0b rsp_flag=%0h", db_in_valid, rsp_flag);
    chk_all_zero("async reset");
    step();
    eth_rst_n = 1'b1;
    db_ready  = 1'b1;
    db_out_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      db_out_flag = 4'(i + 1);
      step();
      $display("late reply %0d: rsp_valid=%b", i, rsp_valid);
      chk($sformatf("late%0d rsp_valid", i), 96'(rsp_valid), 96'h0);
    end
    db_out_valid = 1'b0;
    step();
    chk("late spurious cnt", 96'(spurious_cnt), STATS ? 96'h3 : 96'h0);
    chk("late db_in_valid", 96'(db_in_valid), 96'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
